// File: rtl/wr_en_demux_n_if.sv
// wr_en_demux_n_if: command-side bundle for wr_en_demux_n
// Ports: master drives en, sel, load_sel, inc_mode, clr_err and observes we, ptr, wrap, err;
// slave is the router side with the directions reversed.
interface wr_en_demux_n_if #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
);
    logic             en;
    logic [SEL_W-1:0] sel;
    logic             load_sel;
    logic             inc_mode;
    logic             clr_err;
    logic [N_CH-1:0]  we;
    logic [SEL_W-1:0] ptr;
    logic             wrap;
    logic             err;
    modport master (output en, sel, load_sel, inc_mode, clr_err, input we, ptr, wrap, err);
    modport slave (input en, sel, load_sel, inc_mode, clr_err, output we, ptr, wrap, err);
endinterface

// File: rtl/wr_en_demux_n.sv
// wr_en_demux_n: routes a write strobe to one of N_CH register-bank enables via a loadable pointer
// Ports: clk_i (rising edge), rst_n_i (synchronous, active-low), bus (wr_en_demux_n_if.slave):
//   en/sel/load_sel/inc_mode/clr_err in; we (registered one-hot), ptr, wrap (pulse), err (sticky) out.
// Macro WR_DEMUX_AUTOINC_EN: when defined, inc_mode steps the pointer after each routed strobe and
//   wrap pulses on the N_CH-1 -> 0 step; otherwise inc_mode is ignored and wrap stays 0.
module wr_en_demux_n #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input logic            clk_i,
    input logic            rst_n_i,
    wr_en_demux_n_if.slave bus
);
    localparam logic [SEL_W:0]   N_L  = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);
    logic [SEL_W-1:0] tgt, nxt, ptr_q, ptr_d;
    logic [N_CH-1:0]  we_q, we_d;
    logic             valid, last, inc, wrap_q, wrap_d, err_q, err_d;
`ifdef WR_DEMUX_AUTOINC_EN
    assign inc = bus.inc_mode;
`else
    assign inc = 1'b0;
`endif
    always_comb begin
        // load bypass: a load in the same cycle as a strobe routes to the new channel
        tgt    = bus.load_sel ? bus.sel : ptr_q;
        valid  = {1'b0, tgt} < N_L;
        last   = tgt == LAST;
        nxt    = last ? '0 : tgt + 1'b1;
        we_d   = (bus.en && valid) ? {{(N_CH-1){1'b0}}, 1'b1} << tgt : '0;
        wrap_d = bus.en && valid && inc && last;
        // an out-of-range target leaves the pointer alone
        ptr_d  = !valid ? ptr_q : (bus.en && inc) ? nxt : (bus.en || bus.load_sel) ? tgt : ptr_q;
        // a new error wins over a simultaneous clear
        err_d  = !valid || (err_q && !bus.clr_err);
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            we_q   <= '0;
            ptr_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end
    assign bus.we   = we_q;
    assign bus.ptr  = ptr_q;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_wr_en_demux_n.sv
// tb_wr_en_demux_n: randomized and directed checks of wr_en_demux_n for N_CH=4 and N_CH=3
module tb_wr_en_demux_n;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, ld = 1'b0, inc = 1'b0, clr = 1'b0;
    logic [1:0] sel = '0;
    int         checks = 0, failures = 0;
    int         p4 = 0, p3 = 0, we4 = 0, we3 = 0;
    bit         e4 = 0, e3 = 0, w4 = 0, w3 = 0;
    bit         autoinc;

    wr_en_demux_n_if #(.N_CH(4)) b4 ();
    wr_en_demux_n_if #(.N_CH(3)) b3 ();
    assign b4.en = en;  assign b4.sel = sel; assign b4.load_sel = ld;
    assign b4.inc_mode = inc; assign b4.clr_err = clr;
    assign b3.en = en;  assign b3.sel = sel; assign b3.load_sel = ld;
    assign b3.inc_mode = inc; assign b3.clr_err = clr;

    wr_en_demux_n #(.N_CH(4)) d4 (.clk_i(clk), .rst_n_i(rst_n), .bus(b4));
    wr_en_demux_n #(.N_CH(3)) d3 (.clk_i(clk), .rst_n_i(rst_n), .bus(b3));

    always #5 clk = ~clk;

    // Behavioural model: channel arithmetic straight from the routing rules.
    task automatic model(input int n, inout int ptr, inout bit err, output int we, output bit wrap);
        int t;
        we = 0; wrap = 0;
        if (!rst_n) begin
            ptr = 0; err = 0;
            return;
        end
        t = ld ? int'(sel) : ptr;
        if (t >= n) begin
            err = 1;
            return;
        end
        if (clr) err = 0;
        if (en) begin
            we = 1 << t;
            if (autoinc && inc) begin
                wrap = (t == n - 1);
                ptr = (t + 1) % n;
            end else ptr = t;
        end else if (ld) ptr = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model(4, p4, e4, we4, w4);
        model(3, p3, e3, we3, w3);
    endtask

    task automatic test_reset();
        rst_n = 0; en = 1; inc = 1; ld = 1; sel = 2'd1; clr = 0;
        tick();
        checks++;
        if (b4.we !== 4'b0 || b4.ptr !== 2'd0 || b4.wrap !== 1'b0 || b4.err !== 1'b0) begin
            failures++;
            $display("FAIL reset4 got we=%b ptr=%0d wrap=%b err=%b want all 0", b4.we, b4.ptr, b4.wrap, b4.err);
        end
        checks++;
        if (b3.we !== 3'b0 || b3.ptr !== 2'd0 || b3.err !== 1'b0) begin
            failures++;
            $display("FAIL reset3 got we=%b ptr=%0d err=%b want all 0", b3.we, b3.ptr, b3.err);
        end
        rst_n = 1; en = 0; inc = 0; ld = 0;
        tick();
        checks++;
        if (b4.we !== 4'b0 || b4.ptr !== 2'd0 || b4.err !== 1'b0) begin
            failures++;
            $display("FAIL idle got we=%b ptr=%0d err=%b want 0 0 0", b4.we, b4.ptr, b4.err);
        end
    endtask

    task automatic test_single();
        en = 1; inc = 0;
        tick();
        en = 0;
        checks++;
        if (b4.we !== 4'b0001) begin
            failures++;
            $display("FAIL single got we=%b want 0001", b4.we);
        end
        tick();
        checks++;
        if (b4.we !== 4'b0000) begin
            failures++;
            $display("FAIL single_len got we=%b want 0000", b4.we);
        end
    endtask

    task automatic test_load_strobe();
        ld = 1; sel = 2'd2; en = 1; inc = 0;
        tick();
        ld = 0; en = 0;
        checks++;
        if (b4.we !== 4'b0100 || b4.ptr !== 2'd2) begin
            failures++;
            $display("FAIL load_strobe got we=%b ptr=%0d want 0100 2", b4.we, b4.ptr);
        end
    endtask

    task automatic test_back_to_back();
        ld = 1; sel = 2'd2; en = 0;
        tick();
        ld = 0; en = 1; inc = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (b4.we !== 4'(we4) || b4.wrap !== w4 || b4.ptr !== 2'(p4)) begin
                failures++;
                $display("FAIL b2b[%0d] got we=%b wrap=%b ptr=%0d want %b %b %0d",
                         i, b4.we, b4.wrap, b4.ptr, 4'(we4), w4, p4);
            end
        end
        en = 0; inc = 0;
        tick();
        checks++;
        if (b4.ptr !== (autoinc ? 2'd2 : 2'd2) || b4.we !== 4'b0) begin
            failures++;
            $display("FAIL b2b_end got ptr=%0d we=%b want 2 0000", b4.ptr, b4.we);
        end
    endtask

    task automatic test_error();
        int p;
        p = p3;
        ld = 1; sel = 2'd3; en = 1;
        tick();
        checks++;
        if (b3.we !== 3'b0 || b3.err !== 1'b1 || b3.ptr !== 2'(p)) begin
            failures++;
            $display("FAIL err_set got we=%b err=%b ptr=%0d want 000 1 %0d", b3.we, b3.err, b3.ptr, p);
        end
        en = 0; clr = 1;
        tick();
        checks++;
        if (b3.err !== 1'b1) begin
            failures++;
            $display("FAIL err_set_wins got err=%b want 1", b3.err);
        end
        ld = 0;
        tick();
        clr = 0;
        checks++;
        if (b3.err !== 1'b0) begin
            failures++;
            $display("FAIL err_clr got err=%b want 0", b3.err);
        end
    endtask

    task automatic test_reset_strobe();
        en = 1; inc = 1; rst_n = 0;
        tick();
        rst_n = 1; en = 0; inc = 0;
        checks++;
        if (b4.we !== 4'b0 || b4.ptr !== 2'd0) begin
            failures++;
            $display("FAIL reset_strobe got we=%b ptr=%0d want 0000 0", b4.we, b4.ptr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = $urandom_range(0, 29) != 0;
            en    = $urandom_range(0, 1);
            ld    = $urandom_range(0, 3) == 0;
            inc   = $urandom_range(0, 1);
            clr   = $urandom_range(0, 3) == 0;
            sel   = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (b4.we !== 4'(we4) || b4.ptr !== 2'(p4) || b4.wrap !== w4 || b4.err !== e4) begin
                failures++;
                $display("FAIL rand4[%0d] got we=%b ptr=%0d wrap=%b err=%b want %b %0d %b %b",
                         i, b4.we, b4.ptr, b4.wrap, b4.err, 4'(we4), p4, w4, e4);
            end
            checks++;
            if (b3.we !== 3'(we3) || b3.ptr !== 2'(p3) || b3.wrap !== w3 || b3.err !== e3) begin
                failures++;
                $display("FAIL rand3[%0d] got we=%b ptr=%0d wrap=%b err=%b want %b %0d %b %b",
                         i, b3.we, b3.ptr, b3.wrap, b3.err, 3'(we3), p3, w3, e3);
            end
            checks++;
            if ($countones(b4.we) > 1 || $countones(b3.we) > 1) begin
                failures++;
                $display("FAIL onehot[%0d] got we4=%b we3=%b want at most one bit", i, b4.we, b3.we);
            end
        end
        rst_n = 1; en = 0; ld = 0; inc = 0; clr = 0;
    endtask

    initial begin
`ifdef WR_DEMUX_AUTOINC_EN
        autoinc = 1;
`else
        autoinc = 0;
`endif
        test_reset();
        test_single();
        test_load_strobe();
        test_back_to_back();
        test_error();
        test_reset_strobe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
